sti_dac_sched: RTL and testbench

//  Round-robin scheduler sharing one STI_DAC serializer/pixel-writer between two requesters.

---
 rtl/sti_dac_pkg.sv | 18 +
 rtl/sti_dac_sched_rr_arb2.sv | 31 +++
 rtl/sti_dac_sched.sv | 132 +++++++++++++
 tb/tb_sti_dac_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_dac_pkg.sv
// Shared definitions for the STI_DAC scheduler: command field layout and FSM encoding.
package sti_dac_pkg;

    localparam int CMD_W    = 22;
    localparam int DATA_LSB = 0;
    localparam int LEN_LSB  = 16;
    localparam int FILL     = 18;
    localparam int MSB      = 19;
    localparam int LOW      = 20;
    localparam int LAST     = 21;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_END    = 3'd4;

endpackage

// File: rtl/sti_dac_sched_rr_arb2.sv
// Two-way round-robin picker; the pointer only moves when both requesters contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic next_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        next_ptr = ~gnt[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (en && req == 2'b11)
            ptr <= next_ptr;
    end

endmodule

// File: rtl/sti_dac_sched.sv
// Round-robin scheduler sharing one STI_DAC converter between two requesters,
// with capture of the pi_* command, so_valid completion detection and watchdogs.
module sti_dac_sched
    import sti_dac_pkg::*;
#(
    parameter int CMD_W       = sti_dac_pkg::CMD_W,
    parameter int RUN_TIMEOUT = 128,
    parameter int FIN_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    output logic [1:0]       ack,
    output logic [1:0]       done,
    output logic             load,
    output logic [15:0]      pi_data,
    output logic [1:0]       pi_length,
    output logic             pi_fill,
    output logic             pi_msb,
    output logic             pi_low,
    output logic             pi_end,
    input  logic             so_valid,
    input  logic             pixel_finish,
    output logic             busy,
    output logic             grant_id,
    output logic             all_done,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(FIN_TIMEOUT);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             sov_q;
    logic [1:0]       gnt;
    logic             rr_ptr;
    logic             pick;
    logic             win;
    logic [CMD_W-1:0] cmd_sel;
    logic             complete;
    logic             cnt_sat;

    assign pick     = (state == S_IDLE) && (req != 2'b00);
    assign win      = gnt[1];
    assign cmd_sel  = win ? cmd1 : cmd0;
    assign complete = sov_q & ~so_valid;
    assign cnt_sat  = (cnt == {CNT_W{1'b1}});
    assign busy     = (state != S_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (pick),
        .gnt   (gnt),
        .ptr   (rr_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sov_q       <= 1'b0;
            ack         <= 2'b00;
            done        <= 2'b00;
            load        <= 1'b0;
            pi_data     <= '0;
            pi_length   <= '0;
            pi_fill     <= 1'b0;
            pi_msb      <= 1'b0;
            pi_low      <= 1'b0;
            pi_end      <= 1'b0;
            grant_id    <= 1'b0;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack   <= 2'b00;
            done  <= 2'b00;
            load  <= 1'b0;
            sov_q <= so_valid;
            case (state)
                S_IDLE: begin
                    if (pick) begin
                        pi_data   <= cmd_sel[DATA_LSB +: 16];
                        pi_length <= cmd_sel[LEN_LSB +: 2];
                        pi_fill   <= cmd_sel[FILL];
                        pi_msb    <= cmd_sel[MSB];
                        pi_low    <= cmd_sel[LOW];
                        pi_end    <= cmd_sel[LAST];
                        ack       <= gnt;
                        grant_id  <= win;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load  <= 1'b1;
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // A falling edge of so_valid beats a coincident watchdog expiry.
                    if (complete) begin
                        done  <= grant_id ? 2'b10 : 2'b01;
                        cnt   <= '0;
                        state <= pi_end ? S_FINISH : S_IDLE;
                    end else if (cnt == CNT_W'(RUN_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (pixel_finish) begin
                        all_done <= 1'b1;
                        state    <= S_END;
                    end else if (cnt == CNT_W'(FIN_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_END;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_END: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sti_dac_sched.sv
// Directed bench for sti_dac_sched with a small negedge-driven converter model.
module tb_sti_dac_sched;
    import sti_dac_pkg::*;

    localparam int RUN_TIMEOUT = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [21:0] cmd0 = '0;
    logic [21:0] cmd1 = '0;
    logic [1:0]  ack, done;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        so_valid = 1'b0;
    logic        pixel_finish = 1'b0;
    logic        busy, grant_id, all_done, timeout_err;

    int n_chk = 0;
    int n_pass = 0;

    sti_dac_sched #(.CMD_W(22), .RUN_TIMEOUT(RUN_TIMEOUT), .FIN_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .ack(ack), .done(done), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .pixel_finish(pixel_finish), .busy(busy),
        .grant_id(grant_id), .all_done(all_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Converter model: so_valid rises after load and stays high sv_len cycles (forever if hang).
    int sv_len = 3;
    bit hang = 1'b0;
    int sv_cnt = 0;
    always @(negedge clk) begin
        if (!reset)                 sv_cnt = 0;
        else if (load)              sv_cnt = sv_len;
        else if (sv_cnt > 0 && !hang) sv_cnt = sv_cnt - 1;
        so_valid = (sv_cnt != 0);
    end

    function automatic logic [21:0] mk(input logic last, input logic low, input logic msb,
                                       input logic fill, input logic [1:0] len, input logic [15:0] d);
        return {last, low, msb, fill, len, d};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; hang = 1'b0; pixel_finish = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack != 2'b00) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fall(output bit ok, output bit early);
        ok = 1'b0; early = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!so_valid) begin ok = 1'b1; break; end
            if (done !== 2'b00) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 2'b00;
        tick();
        n_chk++; if ({ack, done, load, busy, grant_id, all_done, timeout_err} !== 10'd0)
            $display("FAIL reset_ctrl: got %b required 0", {ack, done, load, busy, grant_id, all_done, timeout_err});
        else n_pass++;
        n_chk++; if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== 22'd0)
            $display("FAIL reset_pi: got %h required 0", {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end});
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok, early;
        sv_len = 3;
        cmd0 = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'hA55A);
        req = 2'b01;
        tick();
        n_chk++; if (ack !== 2'b01 || load !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_ack: ack=%b load=%b busy=%b required 01/0/1", ack, load, busy);
        else n_pass++;
        req = 2'b00;
        tick();
        n_chk++; if (load !== 1'b1 || ack !== 2'b00 || pi_data !== 16'hA55A || pi_length !== 2'd3 || pi_end !== 1'b0)
            $display("FAIL single_load: load=%b ack=%b data=%h len=%0d end=%b", load, ack, pi_data, pi_length, pi_end);
        else n_pass++;
        wait_fall(ok, early);
        n_chk++; if (!ok || early || done !== 2'b01 || busy !== 1'b0)
            $display("FAIL single_done: ok=%b early=%b done=%b busy=%b required 1/0/01/0", ok, early, done, busy);
        else n_pass++;
        tick();
        n_chk++; if (done !== 2'b00 || load !== 1'b0)
            $display("FAIL single_done_pulse: done=%b load=%b required 00/0", done, load);
        else n_pass++;
    endtask

    task automatic test_pi_stable();
        logic [21:0] ref_cmd;
        bit bad = 1'b0;
        bit seen = 1'b0;
        sv_len = 4;
        ref_cmd = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h1234);
        cmd0 = ref_cmd;
        req = 2'b01;
        tick();
        req = 2'b00;
        for (int i = 0; i < 40; i++) begin
            cmd0 = ~cmd0;
            tick();
            if ({pi_end, pi_low, pi_msb, pi_fill, pi_length, pi_data} !== ref_cmd) bad = 1'b1;
            if (done == 2'b01) begin seen = 1'b1; break; end
        end
        n_chk++; if (bad || !seen)
            $display("FAIL pi_stable: bad=%b done_seen=%b required 0/1", bad, seen);
        else n_pass++;
        n_chk++; if (pi_data !== 16'h1234 || pi_msb !== 1'b1 || pi_low !== 1'b1 || pi_length !== 2'd2)
            $display("FAIL pi_value: data=%h msb=%b low=%b len=%0d required 1234/1/1/2", pi_data, pi_msb, pi_low, pi_length);
        else n_pass++;
    endtask

    task automatic test_rr();
        bit ok, early;
        logic [1:0] exp;
        sv_len = 2;
        cmd0 = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0000);
        cmd1 = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h1111);
        reset = 1'b0; req = 2'b11;
        tick(); tick();
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            wait_ack(ok);
            n_chk++; if (!ok || ack !== exp || grant_id !== exp[1])
                $display("FAIL rr_grant%0d: ok=%b ack=%b gid=%b required %b", t, ok, ack, grant_id, exp);
            else n_pass++;
            tick();
            wait_fall(ok, early);
            n_chk++; if (!ok || early || done !== exp)
                $display("FAIL rr_done%0d: ok=%b done=%b required %b", t, ok, done, exp);
            else n_pass++;
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_last();
        bit ok, early;
        bit stray = 1'b0;
        sv_len = 2;
        cmd1 = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'hBEEF);
        req = 2'b10;
        tick();
        n_chk++; if (ack !== 2'b10)
            $display("FAIL last_ack: got %b required 10", ack);
        else n_pass++;
        req = 2'b00;
        tick();
        n_chk++; if (pi_end !== 1'b1 || load !== 1'b1 || pi_length !== 2'd0 || pi_data !== 16'hBEEF)
            $display("FAIL last_pi: end=%b load=%b len=%0d data=%h", pi_end, load, pi_length, pi_data);
        else n_pass++;
        wait_fall(ok, early);
        n_chk++; if (!ok || done !== 2'b10 || busy !== 1'b1)
            $display("FAIL last_finish: ok=%b done=%b busy=%b required 1/10/1", ok, done, busy);
        else n_pass++;
        tick(); tick();
        n_chk++; if (all_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL finish_wait: all_done=%b busy=%b required 0/1", all_done, busy);
        else n_pass++;
        pixel_finish = 1'b1;
        tick();
        pixel_finish = 1'b0;
        n_chk++; if (all_done !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0)
            $display("FAIL all_done: all_done=%b busy=%b terr=%b required 1/1/0", all_done, busy, timeout_err);
        else n_pass++;
        req = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack !== 2'b00 || load !== 1'b0) stray = 1'b1;
        end
        n_chk++; if (stray || all_done !== 1'b1)
            $display("FAIL end_absorb: stray=%b all_done=%b required 0/1", stray, all_done);
        else n_pass++;
        req = 2'b00;
    endtask

    task automatic test_timeout();
        bit stray = 1'b0;
        do_reset();
        sv_len = 3; hang = 1'b1;
        cmd0 = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0F0F);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        for (int i = 0; i < RUN_TIMEOUT - 1; i++) begin
            tick();
            if (done !== 2'b00) stray = 1'b1;
        end
        n_chk++; if (timeout_err !== 1'b0 || busy !== 1'b1 || stray)
            $display("FAIL tmo_early: terr=%b busy=%b stray_done=%b required 0/1/0", timeout_err, busy, stray);
        else n_pass++;
        tick();
        n_chk++; if (timeout_err !== 1'b1 || busy !== 1'b0 || done !== 2'b00)
            $display("FAIL tmo_fire: terr=%b busy=%b done=%b required 1/0/00", timeout_err, busy, done);
        else n_pass++;
        hang = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok, early;
        do_reset();
        sv_len = 8;
        cmd0 = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'h00FF);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        n_chk++; if (load !== 1'b1 || busy !== 1'b1)
            $display("FAIL ares_pre: load=%b busy=%b required 1/1", load, busy);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_chk++; if (load !== 1'b0 || ack !== 2'b00 || done !== 2'b00 || busy !== 1'b0)
            $display("FAIL ares_async: load=%b ack=%b done=%b busy=%b required 0", load, ack, done, busy);
        else n_pass++;
        tick(); tick();
        reset = 1'b1;
        tick();
        sv_len = 2;
        cmd1 = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h5AA5);
        req = 2'b10;
        tick();
        n_chk++; if (ack !== 2'b10 || grant_id !== 1'b1)
            $display("FAIL ares_regrant: ack=%b gid=%b required 10/1", ack, grant_id);
        else n_pass++;
        req = 2'b00;
        tick();
        wait_fall(ok, early);
        n_chk++; if (!ok || early || done !== 2'b10 || pi_data !== 16'h5AA5)
            $display("FAIL ares_done: ok=%b done=%b data=%h required 1/10/5aa5", ok, done, pi_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_pi_stable();
        test_rr();
        test_last();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
